alu_seq: RTL and testbench

- Parametrised, registered successor to the team's combinational add/sub ALU.
- Adds logic, shift, compare and an iterative multiply.
- Flags: zero, neg, carry, overflow.
- Uses valid/ready handshakes on input and output, so it can sit between a decode stage and a writeback stage with back-pressure.
- Single-cycle ops take 1 cycle. MUL is multi-cycle.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle logic/arith/shift/compare
// ops plus a fixed-latency shift-add multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLTU = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             ovf_q;
  logic             illegal_q;

  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             illegal_d;
  logic [WIDTH-1:0] acc_d;
  logic             accept;

  // Reset gates in_ready so nothing is accepted while rst_n is low.
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign add_res = {1'b0, in1} + {1'b0, in2};
  assign sub_res = {1'b0, in1} - {1'b0, in2};
  assign shamt   = in2[SHW-1:0];

  // Single-cycle result and flags; MUL result comes from the iterative path.
  always_comb begin
    res_d     = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (control)
      OP_ADD: begin
        res_d   = add_res[WIDTH-1:0];
        carry_d = add_res[WIDTH];
        ovf_d   = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_res[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = sub_res[WIDTH-1:0];
        carry_d = sub_res[WIDTH];
        ovf_d   = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_res[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  res_d = in1 & in2;
      OP_OR:   res_d = in1 | in2;
      OP_XOR:  res_d = in1 ^ in2;
      OP_SLT:  res_d = WIDTH'($signed(in1) < $signed(in2));
      OP_SLTU: res_d = WIDTH'(in1 < in2);
      OP_SLL:  res_d = in1 << shamt;
      OP_SRL:  res_d = in1 >> shamt;
      OP_SRA:  res_d = WIDTH'($signed(in1) >>> shamt);
      OP_MUL:  res_d = '0;
      default: illegal_d = 1'b1;
    endcase
  end

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Control FSM, multiplier datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (control == OP_MUL) begin
              mcand_q     <= in1;
              mplier_q    <= in2;
              acc_q       <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              state_q     <= ST_MUL;
            end else begin
              out_q       <= res_d;
              zero_q      <= (res_d == '0);
              neg_q       <= res_d[WIDTH-1];
              carry_q     <= carry_d;
              ovf_q       <= ovf_d;
              illegal_q   <= illegal_d;
              out_valid_q <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        // Fixed WIDTH steps, no early-out, so latency is deterministic.
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          out_q       <= acc_q;
          zero_q      <= (acc_q == '0);
          neg_q       <= acc_q[WIDTH-1];
          carry_q     <= 1'b0;
          ovf_q       <= 1'b0;
          illegal_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized ops with
// random back-pressure, checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 32;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLTU = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  typedef struct packed {
    logic         ill;
    logic         ovf;
    logic         carry;
    logic         neg;
    logic         zero;
    logic [W-1:0] res;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [3:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;
  logic         illegal;

  exp_t sbq[$];
  exp_t act_m;
  exp_t exp_m;
  int   checks = 0;
  int   errors = 0;
  bit   ready_rand = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: plain wide integer arithmetic on the opcode meaning.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    longint unsigned ua;
    longint unsigned ub;
    longint          sa;
    longint          sb;
    longint          sr;
    logic [W-1:0]    lo;
    int              sh;
    e  = '0;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (op)
      4'h0: begin
        e.res   = W'(ua + ub);
        e.carry = ((ua + ub) >> 32) != 0;
        sr = sa + sb; lo = W'(sr);
        e.ovf   = sr != longint'($signed(lo));
      end
      4'h1: begin
        e.res   = W'(ua - ub);
        e.carry = ua < ub;
        sr = sa - sb; lo = W'(sr);
        e.ovf   = sr != longint'($signed(lo));
      end
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'h6: e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'h7: e.res = W'(ua << sh);
      4'h8: e.res = W'(ua >> sh);
      4'h9: e.res = W'(sa >>> sh);
      4'hA: e.res = W'(ua * ub);
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 0);
    e.neg  = e.res[W-1];
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic il, input logic ov,
                              input logic ca, input logic ng, input logic zr);
    mk = {il, ov, ca, ng, zr, r};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called just after a rising edge; pushes the expectation in the accept cycle.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int waited);
    waited   = 0;
    in_valid = 1'b1;
    control  = op;
    in1      = a;
    in2      = b;
    while (1'b1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: in_ready never rose for op %0h", op);
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    sbq.push_back(model(op, a, b));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_now(input string name, input exp_t e);
    @(negedge clk);
    check(name, 64'({out_valid, illegal, ovf, carry, neg, zero, out}), 64'({1'b1, e}));
    tick();
  endtask

  // Monitor: every output transfer pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        act_m = {illegal, ovf, carry, neg, zero, out};
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h expected no result", act_m);
        end else begin
          exp_m = sbq.pop_front();
          check("scoreboard", 64'(act_m), 64'(exp_m));
        end
      end
    end
  end

  initial begin
    int w;
    int bad;
    int n;
    logic [3:0] op;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    control   = OP_ADD;
    in1       = 32'd1;
    in2       = 32'd2;
    out_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({in_ready, out_valid, illegal, ovf, carry, neg, zero, out}), 64'(0));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'({in_ready, out_valid}), 64'(2'b10));
    tick();

    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, w);
    expect_now("add_ovf", mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    issue(OP_SUB, 32'd5, 32'd5, w);
    expect_now("sub_zero", mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(OP_SUB, 32'd3, 32'd5, w);
    expect_now("sub_borrow", mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    issue(OP_SRA, 32'h8000_0000, 32'd31, w);
    expect_now("sra_31", mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, w);
    expect_now("slt_neg", mk(32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, w);
    expect_now("sltu_big", mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(OP_SRL, 32'h8000_0001, 32'd32, w);
    expect_now("srl_amount0", mk(32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, w);
    expect_now("illegal_op", mk(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

    // MUL: fixed latency, busy throughout, then back-pressure.
    issue(OP_MUL, 32'h0001_0001, 32'h0001_0001, w);
    out_ready = 1'b0;
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    check("mul_busy", 64'(bad), 64'(0));
    @(negedge clk);
    check("mul_latency", 64'({out_valid, out}), 64'({1'b1, 32'h0002_0001}));
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 32'h0002_0001) bad++;
    end
    check("mul_hold", 64'(bad), 64'(0));
    tick();
    out_ready = 1'b1;
    issue(OP_ADD, 32'd10, 32'd20, w);
    check("add_same_cycle_accept", 64'(w), 64'(0));
    expect_now("add_after_mul", mk(32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset at cycle 10 of a MUL aborts it.
    issue(OP_MUL, 32'hDEAD_BEEF, 32'h0000_0123, w);
    repeat (9) tick();
    rst_n = 1'b0;
    sbq.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_abort", 64'({in_ready, out_valid}), 64'(2'b10));
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("no_result_after_abort", 64'(bad), 64'(0));
    tick();

    // Randomized ops with random back-pressure.
    ready_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      issue(op, rnd_operand(), rnd_operand(), w);
      if ($urandom_range(0, 3) == 0) tick();
    end

    ready_rand = 1'b0;
    out_ready  = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sbq.size()), 64'(0));
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
